// File: rtl/ahb_subordinate_mux.sv
// AHB-Lite subordinate multiplexer: address decode to HSEL, registered data-phase
// select, response/read-data mux, and a built-in default subordinate for unmapped accesses.
module ahb_subordinate_mux #(
  parameter int AddressWidth     = 32,
  parameter int DataWidth        = 32,
  parameter int SubordinateCount = 2,
  parameter logic [SubordinateCount*AddressWidth-1:0] RegionBase = {32'h1000_0000, 32'h0000_0000},
  parameter logic [SubordinateCount*AddressWidth-1:0] RegionMask = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [AddressWidth-1:0]               haddr,
  input  logic [1:0]                            htrans,
  output logic                                  hready,
  output logic                                  hresp,
  output logic [DataWidth-1:0]                  hrdata,
  output logic [SubordinateCount-1:0]           hsel,
  input  logic [SubordinateCount-1:0]           s_hreadyout,
  input  logic [SubordinateCount-1:0]           s_hresp,
  input  logic [SubordinateCount*DataWidth-1:0] s_hrdata,
  output logic [15:0]                           unmapped_count
);

  localparam int IdxW = (SubordinateCount > 1) ? $clog2(SubordinateCount) : 1;

  localparam logic [1:0] ST_OKAY = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic            w_hit;
  logic [IdxW-1:0] w_idx;
  logic            w_err_start;
  logic            w_unused_htrans0;
  logic [1:0]      w_state_nxt;

  logic            r_dsel_def;
  logic [IdxW-1:0] r_dsel_idx;
  logic [1:0]      r_state;
  logic [15:0]     r_unmapped_count;

  assign w_unused_htrans0 = htrans[0];

  // Scan from the top index down so the lowest matching region wins on overlap.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    hsel  = '0;
    for (int i = SubordinateCount - 1; i >= 0; i--) begin
      if ((haddr & RegionMask[i*AddressWidth +: AddressWidth]) ==
          RegionBase[i*AddressWidth +: AddressWidth]) begin
        w_hit = 1'b1;
        w_idx = IdxW'(i);
      end
    end
    if (w_hit) hsel[w_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dsel_def <= 1'b1;
      r_dsel_idx <= '0;
    end else if (hready) begin
      r_dsel_def <= ~w_hit;
      r_dsel_idx <= w_idx;
    end
  end

  // An unmapped active transfer is accepted only when hready is high, which
  // also guarantees dsel becomes DEFAULT on the same edge the FSM enters ERR1.
  assign w_err_start = hready & ~w_hit & htrans[1];

  always_comb begin
    w_state_nxt = ST_OKAY;
    case (r_state)
      ST_OKAY: w_state_nxt = w_err_start ? ST_ERR1 : ST_OKAY;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_err_start ? ST_ERR1 : ST_OKAY;
      default: w_state_nxt = ST_OKAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_OKAY;
      r_unmapped_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_start && (r_unmapped_count != 16'hFFFF)) begin
        r_unmapped_count <= r_unmapped_count + 16'd1;
      end
    end
  end

  always_comb begin
    if (r_dsel_def) begin
      hready = (r_state != ST_ERR1);
      hresp  = (r_state != ST_OKAY);
      hrdata = '0;
    end else begin
      hready = s_hreadyout[r_dsel_idx];
      hresp  = s_hresp[r_dsel_idx];
      hrdata = s_hrdata[r_dsel_idx*DataWidth +: DataWidth];
    end
  end

  assign unmapped_count = r_unmapped_count;

endmodule

// File: doc/ahb_subordinate_mux.md
# ahb_subordinate_mux

AHB-Lite interconnect stage between the Renode AHB manager (`renode_ahb_manager`) and up to `SubordinateCount` AHB subordinates such as `mem_ahb`. It performs address-phase decoding to per-subordinate HSEL and registers the data-phase selection. It multiplexes HRDATA/HREADYOUT/HRESP back to the manager and contains a built-in default subordinate that answers unmapped accesses with a two-cycle ERROR. Write-side signals (HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA) fan out directly to subordinates; they are not routed through this block.

## Interface
- `AddressWidth`, 32, HADDR width.
- `DataWidth`, 32, HRDATA width.
- `SubordinateCount`, 2, number of mapped subordinates N (1..8).
- `RegionBase`, {32'h1000_0000, 32'h0000_0000}, packed N×AddressWidth; entry i is the base of subordinate i (entry 0 in the LSBs).
- `RegionMask`, {32'hF000_0000, 32'hF000_0000}, packed N×AddressWidth; subordinate i matches when `(haddr & mask_i) == base_i`.

Ports:
- `clk`  in  1  bus clock; all state is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `haddr`  in  AddressWidth  manager address-phase address.
- `htrans`  in  2  manager transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- `hready`  out  1  combined HREADY to the manager; also broadcast to every subordinate's HREADYin.
- `hresp`  out  1  combined response to the manager (0 OKAY, 1 ERROR).
- `hrdata`  out  DataWidth  combined read data to the manager.
- `hsel`  out  N  one-hot address-phase select, one bit per subordinate.
- `s_hreadyout`  in  N  per-subordinate HREADYOUT.
- `s_hresp`  in  N  per-subordinate HRESP.
- `s_hrdata`  in  N×DataWidth  per-subordinate HRDATA, packed (subordinate 0 in the LSBs).
- `unmapped_count`  out  16  saturating count of unmapped NONSEQ/SEQ transfers.

## Operation
- **Address decode** (combinational):
  - `hsel[i]` is 1 for the lowest index i whose region matches `haddr`; overlapping regions resolve to the lowest index.
  - `hsel` is driven regardless of `htrans`.
  - No match means `hsel` = 0 and the default subordinate is selected.
- **Data-phase select register `dsel`**:
  - Holds the decoded target, or DEFAULT when no region matches.
  - Loads only on a rising edge where `hready` = 1; it holds while `hready` = 0.
  - Reset value: DEFAULT.
- **Output mux**:
  - When `dsel` = subordinate i: `hready` = `s_hreadyout[i]`, `hresp` = `s_hresp[i]`, `hrdata` = slice i of `s_hrdata`.
  - When `dsel` = DEFAULT: `hrdata` = 0; `hready` and `hresp` come from the default-subordinate FSM.
- **Default subordinate FSM**, states OKAY, ERR1, ERR2:
  - OKAY: `hready` = 1, `hresp` = 0. Moves to ERR1 when `hready` = 1, no region matches, and `htrans[1]` = 1.
  - ERR1: `hready` = 0, `hresp` = 1. Always moves to ERR2.
  - ERR2: `hready` = 1, `hresp` = 1. Moves to ERR1 if the next address phase is also unmapped NONSEQ/SEQ; otherwise moves to OKAY.
  - Unmapped IDLE/BUSY transfers get a zero-wait OKAY and the FSM stays in OKAY.
  - ERR1/ERR2 may only be entered while `dsel` is DEFAULT.
- **`unmapped_count`**:
  - Increments by 1 on each edge where the FSM enters ERR1.
  - Saturates at 16'hFFFF.
  - Reset value: 0.
- **Reset values of outputs**:
  - `hready` = 1, `hresp` = 0, `hrdata` = 0, `unmapped_count` = 0.
  - `hsel` follows `haddr` combinationally.
- **Reset asserted mid-transfer**: FSM goes to OKAY and `dsel` to DEFAULT immediately (asynchronously). Any pending subordinate wait state is abandoned; the subordinates are reset by the same system reset.

## Timing
- Decode adds no cycles: the address phase and the data phase are each one cycle plus wait states, as on a direct connection.
- Subordinate wait states pass through unchanged: `hready` follows `s_hreadyout[dsel]` with zero added latency.
- The two-cycle ERROR meets the AHB-Lite rule: HRESP = 1 is held for two cycles, with HREADY low in the first and high in the second.
- Back-to-back transfers to different subordinates switch `dsel` on the edge that completes the previous data phase. There is no idle cycle and no HRDATA bubble.
- Combinational paths: `haddr` → `hsel`, and `s_*` → manager-side outputs. There is no combinational path from `htrans` to `hready`.

## Test plan
- **Mapped read, subordinate 0**: read `haddr` = 0x0000_0040, NONSEQ; subordinate 0 returns 0xDEAD_BEEF with zero wait → `hsel` = 2'b01 in the address phase; `hrdata` = 0xDEAD_BEEF, `hready` = 1, `hresp` = 0 in the next cycle.
- **Back-to-back with wait states**: 0x1000_0000 (subordinate 1, 2 wait states) followed by 0x0000_0004 (subordinate 0) → `hready` low for exactly 2 cycles; then the second data phase completes the following cycle with subordinate 0's data; `dsel` does not change during the waits.
- **Unmapped access**: NONSEQ to 0x2000_0000 → `hsel` = 0; next cycle `hready` = 0 / `hresp` = 1; following cycle `hready` = 1 / `hresp` = 1; `unmapped_count` = 1.
- **Consecutive unmapped transfers**: three consecutive NONSEQ transfers to 0x3000_0000 → three ERR1/ERR2 pairs with no OKAY cycle between them; `unmapped_count` = 3. An IDLE transfer to 0x3000_0000 gives OKAY with zero wait and no count change.
- **Saturation**: preload via 65 537 unmapped transfers → `unmapped_count` stays at 0xFFFF.
- **Reset in ERR1**: assert `rst` during ERR1 → `hready` = 1 and `hresp` = 0 within the same cycle (asynchronously); after release, a read of 0x0000_0000 completes normally.
